// File: rtl/fp_addsub_pipe_hs.sv
// Multi-cycle floating-point add/subtract {sign, EXP_W exponent, MAN_W fraction} with valid/ready handshakes.
// Define FP_ADDSUB_ROUND_EN for round-to-nearest-even; without it results are truncated.
module fp_addsub_pipe_hs #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clock_100kHz,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   status,
  output logic [2:0]   dbg_state
);
  // Handshake: a word moves on a rising edge where valid && ready are both high; the side
  // holding valid keeps its data stable until then, and ready never depends on valid.

  localparam int DP_W = MAN_W + 4;  // hidden + fraction + G, R, S
  localparam int AC_W = DP_W + 1;   // plus carry
  localparam int XE_W = EXP_W + 2;
  localparam logic signed [XE_W-1:0] ONE     = XE_W'(1);
  localparam logic signed [XE_W-1:0] EXP_OVF = XE_W'((2 ** EXP_W) - 1);
  localparam logic        [XE_W-1:0] D_MAX   = XE_W'(MAN_W + 2);
  localparam logic [3:0] ST_EXACT = 4'd0, ST_OVF = 4'd1, ST_UNF = 4'd2, ST_INEXACT = 4'd3;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_DONE} state_t;
  state_t state, state_d;

  logic [W-1:0]             a_q, b_q, result_q;
  logic [3:0]               status_q;
  logic                     res_sign_q, sub_q;
  logic signed [XE_W-1:0]   exp_q;
  logic [DP_W-1:0]          big_q, small_q;
  logic [AC_W-1:0]          acc_q;

  // Alignment: order operands by magnitude, shift the smaller one with sticky collection
  logic [EXP_W-1:0] ea, eb, el, es;
  logic [W-1:0]     l_op, s_op;
  logic [MAN_W:0]   ml, ms;
  logic [XE_W-1:0]  d;
  logic [DP_W-1:0]  s_ext, s_shift;
  logic             swap, s_lost;

  assign ea    = a_q[W-2 -: EXP_W];
  assign eb    = b_q[W-2 -: EXP_W];
  assign swap  = (eb > ea) || ((eb == ea) && (b_q[MAN_W-1:0] > a_q[MAN_W-1:0]));
  assign l_op  = swap ? b_q : a_q;
  assign s_op  = swap ? a_q : b_q;
  assign el    = l_op[W-2 -: EXP_W];
  assign es    = s_op[W-2 -: EXP_W];
  assign ml    = (el == '0) ? '0 : {1'b1, l_op[MAN_W-1:0]};
  assign ms    = (es == '0) ? '0 : {1'b1, s_op[MAN_W-1:0]};
  assign d     = XE_W'(el) - XE_W'(es);
  assign s_ext = {ms, 3'b000};

  always_comb begin
    s_shift = '0;
    s_lost  = 1'b0;
    if (d > D_MAX) begin
      s_shift = {{(DP_W-1){1'b0}}, |ms};
    end else begin
      s_shift    = s_ext >> d;
      s_lost     = |(s_ext & ~({DP_W{1'b1}} << d));
      s_shift[0] = s_shift[0] | s_lost;
    end
  end

  logic [AC_W-1:0] sum;
  assign sum = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});

  // Rounding and final range classification
  logic                   inc, inexact;
  logic [MAN_W+1:0]       mant_r;
  logic signed [XE_W-1:0] exp_f;
  logic [MAN_W-1:0]       frac_f;
  logic [W-1:0]           result_d;
  logic [3:0]             status_d;

  always_comb begin
    inc = 1'b0;
`ifdef FP_ADDSUB_ROUND_EN
    inc = acc_q[2] & (acc_q[1] | acc_q[0] | acc_q[3]);
`endif
    inexact = |acc_q[2:0];
    mant_r  = {1'b0, acc_q[AC_W-2:3]} + {{(MAN_W+1){1'b0}}, inc};
    exp_f   = mant_r[MAN_W+1] ? exp_q + ONE : exp_q;
    frac_f  = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    if (exp_f >= EXP_OVF) begin
      result_d = {res_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      status_d = ST_OVF;
    end else if (exp_f < ONE) begin
      result_d = {res_sign_q, {(W-1){1'b0}}};
      status_d = ST_UNF;
    end else begin
      result_d = {res_sign_q, exp_f[EXP_W-1:0], frac_f};
      status_d = inexact ? ST_INEXACT : ST_EXACT;
    end
  end

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (in_valid) state_d = S_ALIGN;
      S_ALIGN:  state_d = S_ADDSUB;
      S_ADDSUB: state_d = (sum == '0) ? S_DONE : S_NORM;
      S_NORM:   if (!acc_q[AC_W-1] && acc_q[AC_W-2]) state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      status_q   <= '0;
      res_sign_q <= 1'b0;
      sub_q      <= 1'b0;
      exp_q      <= '0;
      big_q      <= '0;
      small_q    <= '0;
      acc_q      <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_q <= op_a;
          b_q <= {op_b[W-1] ^ op_sub, op_b[W-2:0]};
        end
        S_ALIGN: begin
          res_sign_q <= l_op[W-1];
          sub_q      <= l_op[W-1] ^ s_op[W-1];
          exp_q      <= XE_W'(el);
          big_q      <= {ml, 3'b000};
          small_q    <= s_shift;
        end
        S_ADDSUB: begin
          acc_q <= sum;
          if (sum == '0) begin
            result_q <= '0;
            status_q <= ST_EXACT;
          end
        end
        S_NORM: begin
          if (acc_q[AC_W-1]) begin
            acc_q <= {1'b0, acc_q[AC_W-1:2], acc_q[1] | acc_q[0]};
            exp_q <= exp_q + ONE;
          end else if (!acc_q[AC_W-2]) begin
            acc_q <= {acc_q[AC_W-2:0], 1'b0};
            exp_q <= exp_q - ONE;
          end
        end
        S_ROUND: begin
          result_q <= result_d;
          status_q <= status_d;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = result_q;
  assign status    = status_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_fp_addsub_pipe_hs.sv
// Bench for fp_addsub_pipe_hs: directed vector table, handshake/reset sequences and random
// operands scored against an exact-integer reference model.
module tb_fp_addsub_pipe_hs;
  localparam int EXP_W = 6;
  localparam int MAN_W = 25;
  localparam int W = 1 + EXP_W + MAN_W;

  logic         clock_100kHz = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [W-1:0] op_a, op_b, result;
  logic [3:0]   status;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W+3:0] exp_q[$];

  fp_addsub_pipe_hs #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clock_100kHz(clock_100kHz), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .status(status), .dbg_state(dbg_state)
  );

  always #5 clock_100kHz = ~clock_100kHz;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Exact value of an operand is mant * 2^(exp - bias - MAN_W); both operands share that
  // scale, so the sum is an exact integer that gets rounded once.
  function automatic logic [W+3:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub);
    logic [127:0] va, vb, mag, q, rem, half, one;
    logic         sa, sb, sr, inexact;
    logic [W-1:0] res;
    logic [3:0]   st;
    int           p, e, sh;
    one = 128'd1;
    sa  = a[W-1];
    sb  = b[W-1] ^ sub;
    va  = (a[W-2 -: EXP_W] == '0) ? '0 : ((one << MAN_W) | 128'(a[MAN_W-1:0])) << a[W-2 -: EXP_W];
    vb  = (b[W-2 -: EXP_W] == '0) ? '0 : ((one << MAN_W) | 128'(b[MAN_W-1:0])) << b[W-2 -: EXP_W];
    if (sa == sb)      begin mag = va + vb; sr = sa; end
    else if (va >= vb) begin mag = va - vb; sr = sa; end
    else               begin mag = vb - va; sr = sb; end
    if (mag == '0) return {4'd0, {W{1'b0}}};
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e = p - MAN_W;
    if (p > MAN_W) begin
      sh   = p - MAN_W;
      q    = mag >> sh;
      rem  = mag & ((one << sh) - one);
      half = one << (sh - 1);
    end else begin
      q    = mag << (MAN_W - p);
      rem  = '0;
      half = '0;
    end
    inexact = (rem != '0);
`ifdef FP_ADDSUB_ROUND_EN
    if (rem > half || (rem == half && rem != '0 && q[0])) q = q + one;
    if (q[MAN_W+1]) begin q = q >> 1; e = e + 1; end
`endif
    if (e >= (1 << EXP_W) - 1) begin
      res = {sr, {EXP_W{1'b1}}, {MAN_W{1'b0}}}; st = 4'd1;
    end else if (e < 1) begin
      res = {sr, {(W-1){1'b0}}}; st = 4'd2;
    end else begin
      res = {sr, EXP_W'(e), q[MAN_W-1:0]}; st = inexact ? 4'd3 : 4'd0;
    end
    return {st, res};
  endfunction

  // One full transaction; 'stall' holds out_ready low for that many cycles once out_valid rises.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input int stall, output logic [W-1:0] res, output logic [3:0] st,
                       output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clock_100kHz); #1; guard++; end
    check("in_ready_before_accept", 64'(in_ready), 64'(1));
    out_ready = (stall == 0);
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clock_100kHz); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clock_100kHz); #1; lat++; end
    check("out_valid_within_budget", 64'(out_valid), 64'(1));
    res = result;
    st  = status;
    for (int k = 0; k < stall; k++) begin
      @(posedge clock_100kHz); #1;
      check("stall_result_hold", 64'(result), 64'(res));
      check("stall_valid_hold", 64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    @(posedge clock_100kHz); #1;
    check("out_valid_drop", 64'(out_valid), 64'(0));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic [3:0]   st;
    int           lat;
  } vec_t;

  vec_t         vecs[10];
  logic [W-1:0] r, ra, rb;
  logic [3:0]   s;
  logic [W+3:0] want;
  int           lat, ea, eb, t;

  initial begin
    in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock_100kHz);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    check("reset_status", 64'(status), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_state_zero", 64'(dbg_state), 64'(0));
    reset = 1'b1;
    @(posedge clock_100kHz); #1;
    check("post_reset_in_ready", 64'(in_ready), 64'(1));

    vecs[0] = '{32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'd0, 5};
    vecs[1] = '{32'h3E000000, 32'h3E000000, 1'b1, 32'h00000000, 4'd0, -1};
    vecs[2] = '{32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, 32'h7E000000, 4'd1, -1};
    vecs[3] = '{32'h02000001, 32'h02000000, 1'b1, 32'h00000000, 4'd2, -1};
    vecs[5] = '{32'hBE000000, 32'hBE000000, 1'b0, 32'hC0000000, 4'd0, -1};
    vecs[7] = '{32'h3E000000, 32'h00000000, 1'b0, 32'h3E000000, 4'd0, -1};
    vecs[9] = '{32'h40000000, 32'h3E000000, 1'b1, 32'h3E000000, 4'd0, -1};
`ifdef FP_ADDSUB_ROUND_EN
    vecs[4] = '{32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000002, 4'd3, -1};
    vecs[6] = '{32'h3E000000, 32'h02000000, 1'b1, 32'h3E000000, 4'd3, -1};
    vecs[8] = '{32'h02000000, 32'h3E000000, 1'b1, 32'hBE000000, 4'd3, -1};
`else
    vecs[4] = '{32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000001, 4'd3, -1};
    vecs[6] = '{32'h3E000000, 32'h02000000, 1'b1, 32'h3DFFFFFF, 4'd3, -1};
    vecs[8] = '{32'h02000000, 32'h3E000000, 1'b1, 32'hBDFFFFFF, 4'd3, -1};
`endif
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, 0, r, s, lat);
      check($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].res));
      check($sformatf("vec%0d_status", i), 64'(s), 64'(vecs[i].st));
      if (vecs[i].lat >= 0) check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Back-pressure: result held for 6 cycles while a second request is offered and ignored
    out_ready = 1'b0;
    op_a = 32'h3E000000; op_b = 32'h3E000000; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clock_100kHz); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clock_100kHz); #1; lat++; end
    check("bp_valid", 64'(out_valid), 64'(1));
    check("bp_latency", 64'(lat), 64'(5));
    for (int k = 0; k < 6; k++) begin
      op_a = 32'h7DFFFFFF; op_b = 32'h7DFFFFFF; in_valid = 1'b1;
      @(posedge clock_100kHz); #1;
      check("bp_result_hold", 64'(result), 64'h40000000);
      check("bp_status_hold", 64'(status), 64'(0));
      check("bp_valid_hold", 64'(out_valid), 64'(1));
      check("bp_in_ready_low", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock_100kHz); #1;
    check("bp_consumed_valid", 64'(out_valid), 64'(0));
    check("bp_consumed_in_ready", 64'(in_ready), 64'(1));
    for (int k = 0; k < 8; k++) begin
      @(posedge clock_100kHz); #1;
      check("bp_no_phantom_result", 64'(out_valid), 64'(0));
    end

    // Reset while normalizing a long cancellation aborts with no output
    op_a = 32'h02000001; op_b = 32'h02000000; op_sub = 1'b1; in_valid = 1'b1;
    @(posedge clock_100kHz); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock_100kHz);
    #1;
    reset = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_result", 64'(result), 64'(0));
    check("abort_status", 64'(status), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(1));
    @(posedge clock_100kHz); #1;
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock_100kHz); #1;
      check("abort_no_output", 64'(out_valid), 64'(0));
    end
    do_op(32'h3E000000, 32'h3E000000, 1'b0, 0, r, s, lat);
    check("after_abort_result", 64'(r), 64'h40000000);
    check("after_abort_status", 64'(s), 64'(0));

    // Random operands, biased toward close exponents, zeros and the range edges
    for (int i = 0; i < 300; i++) begin
      ea = ($urandom_range(3, 0) == 0) ? (($urandom_range(1, 0) == 1) ? $urandom_range(2, 1)
                                                                      : $urandom_range(62, 61))
                                       : $urandom_range(62, 1);
      case ($urandom_range(4, 0))
        0:       eb = $urandom_range(62, 1);
        1:       begin t = ea - $urandom_range(2, 0); eb = (t < 1) ? 1 : t; end
        2:       eb = 0;
        3:       eb = ea;
        default: eb = ea - $urandom_range(ea - 1, 0);
      endcase
      ra = {1'($urandom), EXP_W'(ea), MAN_W'($urandom)};
      rb = {1'($urandom), EXP_W'(eb),
            ($urandom_range(3, 0) == 0) ? ra[MAN_W-1:0] : MAN_W'($urandom)};
      if ($urandom_range(1, 0) == 1) begin r = ra; ra = rb; rb = r; end
      op_sub = 1'($urandom);
      exp_q.push_back(ref_model(ra, rb, op_sub));
      repeat ($urandom_range(2, 0)) @(posedge clock_100kHz);
      #1;
      do_op(ra, rb, op_sub, ((i % 4) == 0) ? $urandom_range(3, 1) : 0, r, s, lat);
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 64'(0), 64'(1));
      end else begin
        want = exp_q.pop_front();
        check($sformatf("rand%0d_result a=%h b=%h", i, ra, rb), 64'(r), 64'(want[W-1:0]));
        check($sformatf("rand%0d_status a=%h b=%h", i, ra, rb), 64'(s), 64'(want[W+3:W]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
